// File: rtl/div_32bits_seq.sv
// Multi-cycle restoring divider for DIV/DIVU: one quotient bit per clock,
// with a start/busy/done handshake and a divide-by-zero flag.
//
// state | meaning
// IDLE  | waiting for start; results held
// RUN   | one restoring iteration per clock on magnitudes
// FIX   | sign correction / divide-by-zero result, done pulse
module div_32bits_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam int CW = $clog2(WIDTH);

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dsr_mag;
    logic             neg_q;
    logic             neg_r;
    logic             zero_div;

    logic             dvd_neg;
    logic             dsr_neg;
    logic [WIDTH-1:0] dvd_mag_in;
    logic [WIDTH-1:0] dsr_mag_in;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH+1:0] trial;

    always_comb begin
        dvd_neg    = is_signed & dividend[WIDTH-1];
        dsr_neg    = is_signed & divisor[WIDTH-1];
        dvd_mag_in = dvd_neg ? (~dividend + 1'b1) : dividend;
        dsr_mag_in = dsr_neg ? (~divisor + 1'b1) : divisor;
    end

    // Shifted partial remainder can exceed WIDTH bits; an extra top bit acts as the borrow.
    assign rem_sh = {rem, quo[WIDTH-1]};
    assign trial  = {1'b0, rem_sh} - {2'b00, dsr_mag};

    assign busy = (state == S_RUN) || (state == S_FIX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            rem         <= '0;
            quo         <= '0;
            dsr_mag     <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            zero_div    <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        neg_q       <= dvd_neg ^ dsr_neg;
                        neg_r       <= dvd_neg;
                        rem         <= '0;
                        cnt         <= CW'(WIDTH - 1);
                        dsr_mag     <= dsr_mag_in;
                        div_by_zero <= 1'b0;
                        if (divisor == '0) begin
                            // Raw dividend is parked in quo so FIX can return it as the remainder.
                            zero_div <= 1'b1;
                            quo      <= dividend;
                            state    <= S_FIX;
                        end else begin
                            zero_div <= 1'b0;
                            quo      <= dvd_mag_in;
                            state    <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    quo <= {quo[WIDTH-2:0], ~trial[WIDTH+1]};
                    rem <= trial[WIDTH+1] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) begin
                        state <= S_FIX;
                    end
                end
                S_FIX: begin
                    state <= S_IDLE;
                    done  <= 1'b1;
                    if (zero_div) begin
                        quotient    <= '1;
                        remainder   <= quo;
                        div_by_zero <= 1'b1;
                    end else begin
                        quotient    <= neg_q ? (~quo + 1'b1) : quo;
                        remainder   <= neg_r ? (~rem + 1'b1) : rem;
                        div_by_zero <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
